// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: default geometry and width calculations used by the RX and TX FIFOs.
package fifo_pkg;

   localparam int unsigned DEFAULT_DEPTH      = 8;
   localparam int unsigned DEFAULT_DATA_WIDTH = 8;

   // Bits needed to hold a fill count of 0..depth inclusive.
   function automatic int unsigned count_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   // Bits needed to address entries 0..depth-1, never less than one.
   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// FIFO control: read/write pointers, fill count, level flags and sticky error flags.
module fifo_ptr_ctrl
   import fifo_pkg::*;
#(
   parameter int unsigned DEPTH     = DEFAULT_DEPTH,
   parameter int unsigned AF_THRESH = DEPTH - 1,
   parameter int unsigned AE_THRESH = 1,
   localparam int unsigned CW       = count_width(DEPTH),
   localparam int unsigned PW       = ptr_width(DEPTH)
) (
   input  logic          clk,
   input  logic          n_rst,
   input  logic          clear,
   input  logic          w_enable,
   input  logic          r_enable,
   output logic          w_accept,
   output logic [PW-1:0] wptr,
   output logic [PW-1:0] rptr,
   output logic [CW-1:0] count,
   output logic          empty,
   output logic          full,
   output logic          almost_full,
   output logic          almost_empty,
   output logic          overflow,
   output logic          underflow
);

   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d;
   logic          underflow_q, underflow_d;
   logic          r_accept;

   // Wrap by compare so non-power-of-two depths work.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      empty        = (count_q == '0);
      full         = (count_q == CW'(DEPTH));
      almost_full  = (count_q >= CW'(AF_THRESH));
      almost_empty = (count_q <= CW'(AE_THRESH));
      r_accept     = r_enable & ~empty & ~clear;
      w_accept     = w_enable & (~full | r_accept) & ~clear;
   end

   always_comb begin
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (clear) begin
         wptr_d      = '0;
         rptr_d      = '0;
         count_d     = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (w_accept) wptr_d = ptr_inc(wptr_q);
         if (r_accept) rptr_d = ptr_inc(rptr_q);
         unique case ({w_accept, r_accept})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
         if (w_enable & full & ~r_accept) overflow_d = 1'b1;
         if (r_enable & empty) underflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign wptr      = wptr_q;
   assign rptr      = rptr_q;
   assign count     = count_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule

// File: rtl/flex_rx_fifo.sv
// Parametrised first-word-fall-through receive FIFO; holds the storage array and head mux.
module flex_rx_fifo
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int unsigned DEPTH      = DEFAULT_DEPTH,
   parameter int unsigned AF_THRESH  = DEPTH - 1,
   parameter int unsigned AE_THRESH  = 1,
   localparam int unsigned CW        = count_width(DEPTH)
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  clear,
   input  logic                  w_enable,
   input  logic [DATA_WIDTH-1:0] w_data,
   input  logic                  r_enable,
   output logic [DATA_WIDTH-1:0] r_data,
   output logic                  empty,
   output logic                  full,
   output logic [CW-1:0]         count,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int unsigned PW = ptr_width(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]         wptr;
   logic [PW-1:0]         rptr;
   logic                  w_accept;

   fifo_ptr_ctrl #(
      .DEPTH     (DEPTH),
      .AF_THRESH (AF_THRESH),
      .AE_THRESH (AE_THRESH)
   ) u_ptr_ctrl (
      .clk          (clk),
      .n_rst        (n_rst),
      .clear        (clear),
      .w_enable     (w_enable),
      .r_enable     (r_enable),
      .w_accept     (w_accept),
      .wptr         (wptr),
      .rptr         (rptr),
      .count        (count),
      .empty        (empty),
      .full         (full),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (w_accept) begin
         mem_q[wptr] <= w_data;
      end
   end

   // Head entry is always visible; no bypass, so a write shows up one cycle later.
   assign r_data = mem_q[rptr];

endmodule

// File: tb/tb_flex_rx_fifo.sv
// Self-checking bench: two FIFO builds (depth 8 and depth 5) against a shift-list model.
module tb_flex_rx_fifo;

   localparam int MD  [2] = '{8, 5};
   localparam int MAF [2] = '{7, 4};
   localparam int MAE [2] = '{1, 2};

   logic       tb_clk = 1'b0;
   logic       n_rst;
   logic       clear;
   logic       w_enable;
   logic       r_enable;
   logic [7:0] w_data;

   logic [7:0] r_data0, r_data1;
   logic [3:0] count0;
   logic [2:0] count1;
   logic       empty0, full0, af0, ae0, ovf0, unf0;
   logic       empty1, full1, af1, ae1, ovf1, unf1;

   int         checks = 0;
   int         errors = 0;
   logic       chk_en = 1'b0;

   // Model: entry 0 is the head; pops shift the list down.
   logic [7:0] mdata [2][8];
   int         mcnt  [2];
   logic       movf  [2];
   logic       munf  [2];

   logic [7:0] vals    [8] = '{8'h00, 8'hFF, 8'h00, 8'h0F, 8'hF0, 8'hFF, 8'hFF, 8'h00};
   logic [7:0] exp_seq [8];

   always #5 tb_clk = ~tb_clk;

   flex_rx_fifo #(.DATA_WIDTH(8), .DEPTH(8)) u_dut0 (
      .clk          (tb_clk),
      .n_rst        (n_rst),
      .clear        (clear),
      .w_enable     (w_enable),
      .w_data       (w_data),
      .r_enable     (r_enable),
      .r_data       (r_data0),
      .empty        (empty0),
      .full         (full0),
      .count        (count0),
      .almost_full  (af0),
      .almost_empty (ae0),
      .overflow     (ovf0),
      .underflow    (unf0)
   );

   flex_rx_fifo #(.DATA_WIDTH(8), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(2)) u_dut1 (
      .clk          (tb_clk),
      .n_rst        (n_rst),
      .clear        (clear),
      .w_enable     (w_enable),
      .w_data       (w_data),
      .r_enable     (r_enable),
      .r_data       (r_data1),
      .empty        (empty1),
      .full         (full1),
      .count        (count1),
      .almost_full  (af1),
      .almost_empty (ae1),
      .overflow     (ovf1),
      .underflow    (unf1)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge tb_clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int i = 0; i < 2; i++) begin
            mcnt[i] = 0;
            movf[i] = 1'b0;
            munf[i] = 1'b0;
            for (int j = 0; j < 8; j++) mdata[i][j] = 8'h00;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (clear) begin
               mcnt[i] = 0;
               movf[i] = 1'b0;
               munf[i] = 1'b0;
            end else begin
               bit rd, wr;
               rd = r_enable && (mcnt[i] != 0);
               wr = w_enable && ((mcnt[i] != MD[i]) || rd);
               if (w_enable && !wr) movf[i] = 1'b1;
               if (r_enable && mcnt[i] == 0) munf[i] = 1'b1;
               if (rd) begin
                  for (int j = 0; j < 7; j++) mdata[i][j] = mdata[i][j+1];
                  mcnt[i]--;
               end
               if (wr) begin
                  mdata[i][mcnt[i]] = w_data;
                  mcnt[i]++;
               end
            end
         end
      end
   end

   task automatic check_inst(input int i, input logic [7:0] rd, input int cnt, input logic e,
                             input logic f, input logic af, input logic ae, input logic ov,
                             input logic un);
      chk($sformatf("count%0d", i), cnt, mcnt[i]);
      chk($sformatf("empty%0d", i), int'(e), int'(mcnt[i] == 0));
      chk($sformatf("full%0d", i), int'(f), int'(mcnt[i] == MD[i]));
      chk($sformatf("almost_full%0d", i), int'(af), int'(mcnt[i] >= MAF[i]));
      chk($sformatf("almost_empty%0d", i), int'(ae), int'(mcnt[i] <= MAE[i]));
      chk($sformatf("overflow%0d", i), int'(ov), int'(movf[i]));
      chk($sformatf("underflow%0d", i), int'(un), int'(munf[i]));
      if (mcnt[i] > 0) chk($sformatf("r_data%0d", i), int'(rd), int'(mdata[i][0]));
   endtask

   always @(negedge tb_clk) begin
      if (chk_en) begin
         check_inst(0, r_data0, int'(count0), empty0, full0, af0, ae0, ovf0, unf0);
         check_inst(1, r_data1, int'(count1), empty1, full1, af1, ae1, ovf1, unf1);
      end
   end

   task automatic tick();
      @(posedge tb_clk);
      #1;
   endtask

   task automatic fill();
      for (int k = 0; k < 8; k++) begin
         w_enable = 1'b1;
         w_data   = vals[k];
         tick();
      end
      w_enable = 1'b0;
   endtask

   task automatic drain(input string tag);
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("%s_pop%0d", tag, k), int'(r_data0), int'(exp_seq[k]));
         r_enable = 1'b1;
         tick();
      end
      r_enable = 1'b0;
   endtask

   task automatic check_reset_values();
      chk("rst_count0", int'(count0), 0);
      chk("rst_empty0", int'(empty0), 1);
      chk("rst_full0", int'(full0), 0);
      chk("rst_ae0", int'(ae0), 1);
      chk("rst_af0", int'(af0), 0);
      chk("rst_rdata0", int'(r_data0), 0);
      chk("rst_ovf0", int'(ovf0), 0);
      chk("rst_unf0", int'(unf0), 0);
      chk("rst_count1", int'(count1), 0);
      chk("rst_empty1", int'(empty1), 1);
      chk("rst_rdata1", int'(r_data1), 0);
   endtask

   initial begin
      n_rst    = 1'b0;
      clear    = 1'b0;
      w_enable = 1'b0;
      r_enable = 1'b0;
      w_data   = 8'h00;
      repeat (2) @(posedge tb_clk);
      #1;
      check_reset_values();
      n_rst  = 1'b1;
      chk_en = 1'b1;

      fill();
      chk("fill_full", int'(full0), 1);
      chk("fill_count", int'(count0), 8);
      chk("fill_af", int'(af0), 1);
      chk("fill_empty", int'(empty0), 0);
      chk("fill_rdata", int'(r_data0), 8'h00);
      chk("model_cnt", mcnt[0], 8);
      chk("model_tail", int'(mdata[0][4]), 8'hF0);
      chk("model_d5_ovf", int'(movf[1]), 1);

      for (int k = 0; k < 8; k++) begin
         chk($sformatf("drain_pop%0d", k), int'(r_data0), int'(vals[k]));
         r_enable = 1'b1;
         tick();
         if (k == 5) chk("drain_ae_off", int'(ae0), 0);
         if (k == 6) chk("drain_ae_on", int'(ae0), 1);
      end
      r_enable = 1'b0;
      chk("drain_empty", int'(empty0), 1);
      chk("drain_count", int'(count0), 0);

      fill();
      w_enable = 1'b1;
      w_data   = 8'hAA;
      tick();
      w_enable = 1'b0;
      chk("ovf_flag", int'(ovf0), 1);
      chk("ovf_count", int'(count0), 8);
      chk("ovf_head", int'(r_data0), 8'h00);
      for (int k = 0; k < 8; k++) exp_seq[k] = vals[k];
      drain("ovf");
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clear_ovf", int'(ovf0), 0);

      fill();
      w_enable = 1'b1;
      r_enable = 1'b1;
      w_data   = 8'hAA;
      tick();
      w_enable = 1'b0;
      r_enable = 1'b0;
      chk("wr_full_count", int'(count0), 8);
      chk("wr_full_ovf", int'(ovf0), 0);
      for (int k = 0; k < 7; k++) exp_seq[k] = vals[k+1];
      exp_seq[7] = 8'hAA;
      drain("wr_full");

      w_enable = 1'b1;
      r_enable = 1'b1;
      w_data   = 8'h5A;
      tick();
      w_enable = 1'b0;
      r_enable = 1'b0;
      chk("unf_flag", int'(unf0), 1);
      chk("unf_count", int'(count0), 1);
      chk("unf_rdata", int'(r_data0), 8'h5A);
      chk("unf_empty", int'(empty0), 0);

      for (int k = 0; k < 3; k++) begin
         w_enable = 1'b1;
         w_data   = 8'h30 + 8'(k);
         tick();
      end
      clear = 1'b1;
      w_data = 8'h33;
      tick();
      clear    = 1'b0;
      w_enable = 1'b0;
      chk("clr_count", int'(count0), 0);
      chk("clr_empty", int'(empty0), 1);
      chk("clr_ovf", int'(ovf0), 0);
      chk("clr_unf", int'(unf0), 0);

      // Phased random traffic: fill-heavy, drain-heavy, then balanced, with rare flushes.
      for (int n = 0; n < 600; n++) begin
         int wp, rp;
         case (n / 150)
            0:       begin wp = 80; rp = 30; end
            1:       begin wp = 30; rp = 80; end
            default: begin wp = 55; rp = 50; end
         endcase
         w_enable = ($urandom_range(0, 99) < wp);
         r_enable = ($urandom_range(0, 99) < rp);
         clear    = ($urandom_range(0, 99) < 2);
         w_data   = 8'($urandom);
         tick();
      end
      clear    = 1'b0;
      r_enable = 1'b0;

      for (int k = 0; k < 3; k++) begin
         w_enable = 1'b1;
         w_data   = 8'($urandom);
         tick();
      end
      w_enable = 1'b0;
      #2;
      n_rst = 1'b0;
      #1;
      check_reset_values();
      @(posedge tb_clk);
      #1;
      n_rst = 1'b1;
      tick();
      chk("post_rst_count0", int'(count0), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
